// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 conversion scheduler.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ltc2308_state_e;

  typedef struct packed {
    logic       sd;
    logic       os;
    logic [1:0] sel;
    logic       uni;
    logic       slp;
  } ltc2308_cfg_t;

  localparam int SCK_IDX    = 3;
  localparam int SDO_IDX    = 2;
  localparam int SDI_IDX    = 1;
  localparam int CONVST_IDX = 0;

  localparam int CFG_W  = 6;
  localparam int DATA_W = 12;

  // 1.6 us conversion time expressed in clk cycles
  function automatic int tconv_default(input int clk_rate);
    return clk_rate / 625000;
  endfunction

endpackage

// File: rtl/ltc2308_rr_arb.sv
// Round-robin arbiter: one-hot winner plus the pointer to search from next time.
// LTC2308_SCHED_PRIO0_EN gives requester 0 strict priority without moving the pointer.
module ltc2308_rr_arb
  import ltc2308_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         ptr_nxt,
  output logic [2:0]         win_id
);

  always_comb begin : arb
    int   idx;
    logic found;
    gnt     = '0;
    ptr_nxt = ptr;
    win_id  = '0;
    found   = 1'b0;
    idx     = 0;
`ifdef LTC2308_SCHED_PRIO0_EN
    if (en && req[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_id   = 3'(idx);
        ptr_nxt  = (idx == NUM_REQ - 1) ? 3'd0 : 3'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/ltc2308_sched.sv
// LTC2308 multi-requester scheduler: grants round-robin, runs one bus frame per
// grant, reports results one frame late. Optional macro: LTC2308_SCHED_PRIO0_EN.
module ltc2308_sched
  import ltc2308_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CLK_RATE = 50_000_000,
  parameter int TCONV    = tconv_default(CLK_RATE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [6*NUM_REQ-1:0] req_cfg,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [11:0]          rsp_data,
  output logic                 busy,
  inout  wire  [3:0]           ADC_BUS
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] CONV  = ST_CONV;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;
  localparam logic [7:0] TCONV_LD = 8'(TCONV);

  logic [1:0]         state_q, state_d;
  logic [7:0]         tconv_q, tconv_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic               sck_q, sck_d, convst_q, convst_d;
  ltc2308_cfg_t       cfg_sr_q, cfg_sr_d, last_cfg_q, last_cfg_d, sel_cfg;
  logic [11:0]        shift_in_q, shift_in_d;
  logic               cur_v_q, cur_v_d, pend_v_q, pend_v_d;
  logic [2:0]         cur_id_q, cur_id_d, pend_id_q, pend_id_d, ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [2:0]         rsp_id_q, rsp_id_d;
  logic [11:0]        rsp_data_q, rsp_data_d;
  logic               arb_en;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [2:0]         arb_ptr_nxt, arb_win;
  logic               sdo;

  assign arb_en = (state_q == IDLE);

  ltc2308_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .en      (arb_en),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .ptr_nxt (arb_ptr_nxt),
    .win_id  (arb_win)
  );

  always_comb begin
    sel_cfg = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_gnt[i]) sel_cfg = ltc2308_cfg_t'(req_cfg[6*i +: 6]);
  end

  assign ADC_BUS[SCK_IDX]    = sck_q;
  assign ADC_BUS[SDI_IDX]    = cfg_sr_q.sd;
  assign ADC_BUS[CONVST_IDX] = convst_q;
  assign sdo                 = ADC_BUS[SDO_IDX];

  always_comb begin
    state_d     = state_q;
    tconv_d     = tconv_q;
    bitcnt_d    = bitcnt_q;
    sck_d       = sck_q;
    convst_d    = 1'b0;
    cfg_sr_d    = cfg_sr_q;
    last_cfg_d  = last_cfg_q;
    shift_in_d  = shift_in_q;
    cur_v_d     = cur_v_q;
    cur_id_d    = cur_id_q;
    pend_v_d    = pend_v_q;
    pend_id_d   = pend_id_q;
    ptr_d       = ptr_q;
    grant_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        // A pending result needs one more frame to clock it out, even with no request
        if (|req || pend_v_q) begin
          if (|req) begin
            cfg_sr_d   = sel_cfg;
            last_cfg_d = sel_cfg;
            cur_v_d    = 1'b1;
            cur_id_d   = arb_win;
            grant_d    = arb_gnt;
            ptr_d      = arb_ptr_nxt;
          end else begin
            cfg_sr_d = last_cfg_q;
            cur_v_d  = 1'b0;
          end
          tconv_d  = TCONV_LD;
          convst_d = 1'b1;
          state_d  = CONV;
        end
      end
      CONV: begin
        if (tconv_q <= 8'd1) begin
          state_d  = SHIFT;
          bitcnt_d = 4'd12;
          sck_d    = 1'b0;
        end else begin
          tconv_d = tconv_q - 8'd1;
        end
      end
      SHIFT: begin
        // Sample before the SCK rise, advance SDI after it so SDI holds while SCK is high
        if (!sck_q) begin
          shift_in_d = {shift_in_q[10:0], sdo};
          bitcnt_d   = bitcnt_q - 4'd1;
          sck_d      = 1'b1;
        end else begin
          cfg_sr_d = ltc2308_cfg_t'({cfg_sr_q[4:0], 1'b0});
          sck_d    = 1'b0;
          if (bitcnt_q == 4'd0) state_d = DONE;
        end
      end
      default: begin
        if (pend_v_q) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = pend_id_q;
          rsp_data_d  = shift_in_q;
        end
        pend_v_d  = cur_v_q;
        pend_id_d = cur_id_q;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tconv_q     <= '0;
      bitcnt_q    <= '0;
      sck_q       <= 1'b0;
      convst_q    <= 1'b0;
      cfg_sr_q    <= '0;
      last_cfg_q  <= '0;
      shift_in_q  <= '0;
      cur_v_q     <= 1'b0;
      cur_id_q    <= '0;
      pend_v_q    <= 1'b0;
      pend_id_q   <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tconv_q     <= tconv_d;
      bitcnt_q    <= bitcnt_d;
      sck_q       <= sck_d;
      convst_q    <= convst_d;
      cfg_sr_q    <= cfg_sr_d;
      last_cfg_q  <= last_cfg_d;
      shift_in_q  <= shift_in_d;
      cur_v_q     <= cur_v_d;
      cur_id_q    <= cur_id_d;
      pend_v_q    <= pend_v_d;
      pend_id_q   <= pend_id_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE) | pend_v_q;

endmodule

// File: tb/tb_ltc2308_sched.sv
// Directed bench for ltc2308_sched with an LTC2308 bus model that returns
// {previous frame cfg, 6'h2A} and a running bus-timing checker.
module tb_ltc2308_sched;

  localparam int NUM_REQ  = 4;
  localparam int CLK_RATE = 50_000_000;
  localparam int TCONV    = CLK_RATE / 625000;
  localparam int FRAME    = TCONV + 26;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [23:0] req_cfg = {6'b011111, 6'b100010, 6'b110101, 6'b001100};
  logic [3:0]  grant;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [11:0] rsp_data;
  logic        busy;
  wire  [3:0]  adc_bus;
  logic [11:0] adc_sr = '0;

  assign adc_bus[2] = adc_sr[11];
  wire sck    = adc_bus[3];
  wire sdi    = adc_bus[1];
  wire convst = adc_bus[0];

  ltc2308_sched #(.NUM_REQ(NUM_REQ), .CLK_RATE(CLK_RATE)) dut (
    .clk(clk), .reset(reset), .req(req), .req_cfg(req_cfg), .grant(grant),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
    .ADC_BUS(adc_bus)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int cyc = 0, fcnt = 0;
  int gq[$], gcyc[$], rid[$], rcyc[$];
  logic [11:0] rdat[$];
  logic rbusy[$];
  int convst_err = 0, tconv_err = 0, rise_err = 0, sdi_err = 0, gnt_err = 0;
  int frames_checked = 0, cv_run = 0, since = 0, rises = 0;
  logic fopen = 1'b0, prev_sck = 1'b0, prev_sdi = 1'b0;
  logic [5:0] cap = '0;

  function automatic logic [11:0] code_of(input int id);
    case (id)
      0:       return 12'h32A;
      1:       return 12'hD6A;
      2:       return 12'h8AA;
      default: return 12'h7EA;
    endcase
  endfunction

  // Logger, ADC model and bus checker, all sampled on the falling clk edge
  always @(negedge clk) begin
    cyc++;
    if (|grant) begin
      if (!convst || $countones(grant) != 1) gnt_err++;
      for (int i = 0; i < NUM_REQ; i++) if (grant[i]) gq.push_back(i);
      gcyc.push_back(cyc);
    end
    if (rsp_valid) begin
      rid.push_back(int'(rsp_id)); rdat.push_back(rsp_data);
      rbusy.push_back(busy); rcyc.push_back(cyc);
    end
    if (reset) begin
      fopen = 1'b0; cv_run = 0; rises = 0;
    end else begin
      if (convst) begin
        cv_run++;
        if (cv_run > 1) convst_err++;
        else begin
          if (fopen) begin frames_checked++; if (rises != 12) rise_err++; end
          fopen = 1'b1; rises = 0; since = 0; fcnt++;
          adc_sr = {cap, 6'h2A}; cap = '0;
        end
      end else begin
        cv_run = 0;
        if (fopen) since++;
      end
      if (sck && !prev_sck) begin
        rises++;
        if (rises == 1 && since != TCONV + 1) tconv_err++;
        if (rises <= 6) cap = {cap[4:0], sdi};
      end
      if (sck && sdi !== prev_sdi) sdi_err++;
      if (sck) adc_sr = {adc_sr[10:0], 1'b0};
    end
    prev_sck = sck; prev_sdi = sdi;
  end

  // Runs until the DUT is idle with no request; drops each granted req unless told to hold
  task automatic run_frames(input int max, input int hold_n, input int rearm1, input string nm);
    int ng = 0;
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (|grant) begin
        ng++;
        if (hold_n > 0) begin
          if (ng >= hold_n) req = '0;
        end else if (grant[1] && rearm1 > 0) rearm1--;
        else req = req & ~grant;
      end
      if (!busy && req == '0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: busy=%0b req=%b, required idle within %0d cycles", nm, busy, req, max);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== '0) begin fails++; $display("FAIL rst_grant: got %b want 0", grant); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 3'd0) begin fails++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_data !== 12'h0) begin fails++; $display("FAIL rst_rsp_data: got %h want 000", rsp_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (adc_bus[3] !== 1'b0 || adc_bus[1] !== 1'b0 || adc_bus[0] !== 1'b0) begin
      fails++; $display("FAIL rst_bus: sck/sdi/convst=%b%b%b want 000", adc_bus[3], adc_bus[1], adc_bus[0]);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || convst !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy=%b convst=%b want 0 0", busy, convst);
    end
  endtask

  task automatic test_all_four();
    int gb = gq.size(), rb = rid.size(), fb = fcnt;
    req = 4'b1111;
    run_frames(8 * FRAME, 0, 0, "all4");
    checks++; if (gq.size() - gb != 4) begin fails++; $display("FAIL all4_ngrant: got %0d want 4", gq.size() - gb); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gq[gb+k] != k) begin fails++; $display("FAIL all4_grant%0d: got %0d want %0d", k, gq[gb+k], k); end
      end
      checks++; if (gcyc[gb+3] - gcyc[gb] != 3 * FRAME) begin
        fails++; $display("FAIL all4_grant_span: got %0d want %0d", gcyc[gb+3] - gcyc[gb], 3 * FRAME);
      end
    end
    checks++; if (rid.size() - rb != 4) begin fails++; $display("FAIL all4_nrsp: got %0d want 4", rid.size() - rb); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (rid[rb+k] != k || rdat[rb+k] !== code_of(k)) begin
          fails++; $display("FAIL all4_rsp%0d: got id=%0d data=%h want id=%0d data=%h", k, rid[rb+k], rdat[rb+k], k, code_of(k));
        end
      end
    end
    checks++; if (fcnt - fb != 5) begin fails++; $display("FAIL all4_frames: got %0d want 5", fcnt - fb); end
  endtask

  task automatic test_single();
    int gb = gq.size(), rb = rid.size(), fb = fcnt;
    req = 4'b0100;
    run_frames(4 * FRAME, 0, 0, "single");
    checks++; if (gq.size() - gb != 1 || gq[gb] != 2) begin
      fails++; $display("FAIL single_grant: got n=%0d, want one grant to id 2", gq.size() - gb);
    end
    checks++; if (fcnt - fb != 2) begin fails++; $display("FAIL single_frames: got %0d want 2", fcnt - fb); end
    checks++; if (rid.size() - rb != 1) begin fails++; $display("FAIL single_nrsp: got %0d want 1", rid.size() - rb); end
    else begin
      checks++; if (rid[rb] != 2) begin fails++; $display("FAIL single_id: got %0d want 2", rid[rb]); end
      checks++; if (rdat[rb] !== 12'h8AA) begin fails++; $display("FAIL single_data: got %h want 8aa", rdat[rb]); end
      checks++; if (rbusy[rb] !== 1'b0) begin fails++; $display("FAIL single_busy: got %b want 0", rbusy[rb]); end
      if (gq.size() - gb == 1) begin
        checks++; if (rcyc[rb] - gcyc[gb] != 2 * FRAME - 1) begin
          fails++; $display("FAIL single_latency: got %0d want %0d", rcyc[rb] - gcyc[gb], 2 * FRAME - 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int gb = gq.size(), rb = rid.size(), fb = fcnt;
    req = 4'b0010;
    run_frames(6 * FRAME, 0, 1, "b2b");
    checks++; if (gq.size() - gb != 2) begin fails++; $display("FAIL b2b_ngrant: got %0d want 2", gq.size() - gb); end
    else begin
      checks++; if (gq[gb] != 1 || gq[gb+1] != 1) begin fails++; $display("FAIL b2b_ids: got %0d,%0d want 1,1", gq[gb], gq[gb+1]); end
      checks++; if (gcyc[gb+1] - gcyc[gb] != FRAME) begin
        fails++; $display("FAIL b2b_grant_gap: got %0d want %0d", gcyc[gb+1] - gcyc[gb], FRAME);
      end
    end
    checks++; if (rid.size() - rb != 2) begin fails++; $display("FAIL b2b_nrsp: got %0d want 2", rid.size() - rb); end
    else begin
      checks++; if (rcyc[rb+1] - rcyc[rb] != FRAME) begin
        fails++; $display("FAIL b2b_rsp_gap: got %0d want %0d", rcyc[rb+1] - rcyc[rb], FRAME);
      end
      checks++; if (rid[rb] != 1 || rdat[rb] !== 12'hD6A || rid[rb+1] != 1 || rdat[rb+1] !== 12'hD6A) begin
        fails++; $display("FAIL b2b_data: got %0d/%h %0d/%h want 1/d6a 1/d6a", rid[rb], rdat[rb], rid[rb+1], rdat[rb+1]);
      end
    end
    checks++; if (fcnt - fb != 3) begin fails++; $display("FAIL b2b_frames: got %0d want 3", fcnt - fb); end
  endtask

  task automatic test_reset_mid_frame();
    int rb, fb, highs = 0;
    bit hit = 1'b0;
    req = 4'b1000;
    // Own frame (12 SCK highs) then 6 more into the flush frame carrying id 3
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (grant[3]) req = '0;
      if (sck) begin highs++; if (highs == 18) hit = 1'b1; end
    end
    checks++; if (!hit) begin fails++; $display("FAIL rmf_reach: got %0d SCK highs want 18", highs); end
    @(negedge clk);
    rb = rid.size();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sck !== 1'b0) begin fails++; $display("FAIL rmf_sck: got %b want 0", sck); end
    checks++; if (convst !== 1'b0) begin fails++; $display("FAIL rmf_convst: got %b want 0", convst); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmf_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    fb = fcnt;
    repeat (3 * FRAME) @(negedge clk);
    checks++; if (rid.size() != rb) begin fails++; $display("FAIL rmf_stale_rsp: got %0d responses want 0", rid.size() - rb); end
    checks++; if (fcnt != fb) begin fails++; $display("FAIL rmf_idle: got %0d frames want 0", fcnt - fb); end
    fb = fcnt;
    req = 4'b0100;
    run_frames(4 * FRAME, 0, 0, "rmf_next");
    checks++; if (rid.size() - rb != 1) begin fails++; $display("FAIL rmf_nrsp: got %0d want 1", rid.size() - rb); end
    else begin
      checks++; if (rid[rb] != 2 || rdat[rb] !== 12'h8AA) begin
        fails++; $display("FAIL rmf_next_rsp: got id=%0d data=%h want id=2 data=8aa", rid[rb], rdat[rb]);
      end
    end
    checks++; if (fcnt - fb != 2) begin fails++; $display("FAIL rmf_frames: got %0d want 2", fcnt - fb); end
  endtask

  task automatic test_prio();
    int gb, rb;
    int exp_id[4];
`ifdef LTC2308_SCHED_PRIO0_EN
    exp_id = '{0, 0, 0, 0};
`else
    exp_id = '{0, 1, 3, 0};
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    gb = gq.size(); rb = rid.size();
    req = 4'b1011;
    run_frames(10 * FRAME, 4, 0, "prio");
    checks++; if (gq.size() - gb != 4) begin fails++; $display("FAIL prio_ngrant: got %0d want 4", gq.size() - gb); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gq[gb+k] != exp_id[k]) begin
          fails++; $display("FAIL prio_grant%0d: got %0d want %0d", k, gq[gb+k], exp_id[k]);
        end
      end
    end
    checks++; if (rid.size() - rb != 4) begin fails++; $display("FAIL prio_nrsp: got %0d want 4", rid.size() - rb); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (rid[rb+k] != exp_id[k] || rdat[rb+k] !== code_of(exp_id[k])) begin
          fails++; $display("FAIL prio_rsp%0d: got id=%0d data=%h want id=%0d data=%h", k, rid[rb+k], rdat[rb+k], exp_id[k], code_of(exp_id[k]));
        end
      end
    end
  endtask

  task automatic test_bus_timing();
    checks++; if (convst_err != 0) begin fails++; $display("FAIL bus_convst_width: got %0d violations want 0", convst_err); end
    checks++; if (tconv_err != 0) begin fails++; $display("FAIL bus_tconv: got %0d violations want 0", tconv_err); end
    checks++; if (rise_err != 0) begin fails++; $display("FAIL bus_sck_rises: got %0d frames without 12 rises want 0", rise_err); end
    checks++; if (sdi_err != 0) begin fails++; $display("FAIL bus_sdi_stable: got %0d violations want 0", sdi_err); end
    checks++; if (gnt_err != 0) begin fails++; $display("FAIL bus_grant_convst: got %0d violations want 0", gnt_err); end
    checks++; if (frames_checked < 10) begin fails++; $display("FAIL bus_frames: got %0d checked frames want >=10", frames_checked); end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_prio();
    test_bus_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: time %0t exceeded limit 700000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
